// File: rtl/ray_generator.sv
// Per-frame primary-ray source: scans the image in raster order and emits one camera ray
// per pixel over a valid/ready handshake. Direction is registered together with px/py.
module ray_generator #(
    parameter int                 H_RES = 32,
    parameter int                 V_RES = 24,
    parameter logic signed [11:0] STEP  = 12'sd16,
    parameter logic signed [11:0] FOCAL = 12'sd256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [11:0]         cam_x,
    input  logic signed [11:0]         cam_y,
    input  logic signed [11:0]         cam_z,
    output logic                       ray_valid,
    input  logic                       ray_ready,
    output logic signed [11:0]         ox,
    output logic signed [11:0]         oy,
    output logic signed [11:0]         oz,
    output logic signed [11:0]         dx,
    output logic signed [11:0]         dy,
    output logic signed [11:0]         dz,
    output logic [$clog2(H_RES)-1:0]   px,
    output logic [$clog2(V_RES)-1:0]   py,
    output logic                       sof,
    output logic                       eol,
    output logic                       busy,
    output logic                       done
);

    localparam int PXW = $clog2(H_RES);
    localparam int PYW = $clog2(V_RES);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;
    state_t state;

    logic           hs;
    logic           last_col;
    logic           last_row;
    logic [PXW-1:0] nx;
    logic [PYW-1:0] ny;

    function automatic logic signed [11:0] sat12(input logic signed [23:0] v);
        if (v > 24'sd2047)
            return 12'sd2047;
        else if (v < -24'sd2048)
            return -12'sd2048;
        return v[11:0];
    endfunction

    function automatic logic signed [11:0] dir_x(input logic [PXW-1:0] x);
        logic signed [23:0] d;
        d = ($signed({{(24-PXW){1'b0}}, x}) - 24'(H_RES / 2)) * 24'(STEP);
        return sat12(d);
    endfunction

    // Rows count downward on screen, so dy falls as py rises.
    function automatic logic signed [11:0] dir_y(input logic [PYW-1:0] y);
        logic signed [23:0] d;
        d = (24'(V_RES / 2) - $signed({{(24-PYW){1'b0}}, y})) * 24'(STEP);
        return sat12(d);
    endfunction

    assign hs       = ray_valid & ray_ready;
    assign last_col = (px == PXW'(H_RES - 1));
    assign last_row = (py == PYW'(V_RES - 1));

    always_comb begin
        nx = px + 1'b1;
        ny = py;
        if (last_col) begin
            nx = '0;
            ny = py + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ray_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            px        <= '0;
            py        <= '0;
            ox        <= '0;
            oy        <= '0;
            oz        <= '0;
            dx        <= '0;
            dy        <= '0;
            dz        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ox        <= cam_x;
                        oy        <= cam_y;
                        oz        <= cam_z;
                        px        <= '0;
                        py        <= '0;
                        dx        <= dir_x('0);
                        dy        <= dir_y('0);
                        dz        <= FOCAL;
                        sof       <= 1'b1;
                        eol       <= 1'b0;
                        ray_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (hs) begin
                        if (last_col && last_row) begin
                            ray_valid <= 1'b0;
                            busy      <= 1'b0;
                            sof       <= 1'b0;
                            eol       <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            px  <= nx;
                            py  <= ny;
                            dx  <= dir_x(nx);
                            dy  <= dir_y(ny);
                            sof <= 1'b0;
                            eol <= (nx == PXW'(H_RES - 1));
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_generator.sv
// Scoreboard bench for ray_generator: a small-frame instance for sequencing and a wide-step
// instance for direction saturation.
module tb_ray_generator;

    localparam int                 HA = 4;
    localparam int                 VA = 3;
    localparam logic signed [11:0] SA = 12'sd16;
    localparam logic signed [11:0] FA = 12'sd64;
    localparam int                 HB = 8;
    localparam int                 VB = 2;
    localparam logic signed [11:0] SB = 12'sd1024;
    localparam logic signed [11:0] FB = 12'sd64;

    typedef struct {
        int px, py, dx, dy, dz, ox, oy, oz;
        bit sof, eol, last;
    } ray_t;
    typedef ray_t ray_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_a, start_a, ray_valid_a, ray_ready_a, sof_a, eol_a, busy_a, done_a;
    logic signed [11:0]       cam_x_a, cam_y_a, cam_z_a, ox_a, oy_a, oz_a, dx_a, dy_a, dz_a;
    logic [$clog2(HA)-1:0]    px_a;
    logic [$clog2(VA)-1:0]    py_a;
    logic                     rst_b, start_b, ray_valid_b, ray_ready_b, sof_b, eol_b, busy_b, done_b;
    logic signed [11:0]       cam_x_b, cam_y_b, cam_z_b, ox_b, oy_b, oz_b, dx_b, dy_b, dz_b;
    logic [$clog2(HB)-1:0]    px_b;
    logic [$clog2(VB)-1:0]    py_b;

    ray_generator #(.H_RES(HA), .V_RES(VA), .STEP(SA), .FOCAL(FA)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a),
        .cam_x(cam_x_a), .cam_y(cam_y_a), .cam_z(cam_z_a),
        .ray_valid(ray_valid_a), .ray_ready(ray_ready_a),
        .ox(ox_a), .oy(oy_a), .oz(oz_a), .dx(dx_a), .dy(dy_a), .dz(dz_a),
        .px(px_a), .py(py_a), .sof(sof_a), .eol(eol_a), .busy(busy_a), .done(done_a)
    );

    ray_generator #(.H_RES(HB), .V_RES(VB), .STEP(SB), .FOCAL(FB)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .cam_x(cam_x_b), .cam_y(cam_y_b), .cam_z(cam_z_b),
        .ray_valid(ray_valid_b), .ray_ready(ray_ready_b),
        .ox(ox_b), .oy(oy_b), .oz(oz_b), .dx(dx_b), .dy(dy_b), .dz(dz_b),
        .px(px_b), .py(py_b), .sof(sof_b), .eol(eol_b), .busy(busy_b), .done(done_b)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    ray_t   q_a[$];
    ray_t   q_b[$];
    int     hs_cnt_a = 0, hs_cnt_b = 0;
    int     done_cnt_a = 0, done_cnt_b = 0;
    bit     pend_a = 0, pend_b = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat12m(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic ray_q_t gen_frame(input int h, input int v, input int step, input int focal,
                                         input int cx, input int cy, input int cz);
        ray_q_t f;
        ray_t   r;
        for (int y = 0; y < v; y++) begin
            for (int x = 0; x < h; x++) begin
                r.px = x;  r.py = y;
                r.dx = sat12m((x - h / 2) * step);
                r.dy = sat12m((v / 2 - y) * step);
                r.dz = focal;
                r.ox = cx; r.oy = cy; r.oz = cz;
                r.sof = (x == 0 && y == 0);
                r.eol = (x == h - 1);
                r.last = (x == h - 1 && y == v - 1);
                f.push_back(r);
            end
        end
        return f;
    endfunction

    task automatic cmp_ray(input string p, input ray_t e, input int px, input int py,
                           input int dx, input int dy, input int dz, input int ox, input int oy,
                           input int oz, input int sof, input int eol);
        chk({p, "_px"}, px, e.px);
        chk({p, "_py"}, py, e.py);
        chk({p, "_dx"}, dx, e.dx);
        chk({p, "_dy"}, dy, e.dy);
        chk({p, "_dz"}, dz, e.dz);
        chk({p, "_ox"}, ox, e.ox);
        chk({p, "_oy"}, oy, e.oy);
        chk({p, "_oz"}, oz, e.oz);
        chk({p, "_sof"}, sof, int'(e.sof));
        chk({p, "_eol"}, eol, int'(e.eol));
    endtask

    // Monitors: the head of the queue must be on the outputs whenever valid; pop on handshake.
    initial begin
        ray_t e;
        forever begin
            @(negedge clk);
            chk("done_a", done_a, int'(pend_a));
            if (done_a) done_cnt_a++;
            if (pend_a) chk("valid_after_last_a", ray_valid_a, 0);
            pend_a = 0;
            if (ray_valid_a) begin
                chk("busy_a", busy_a, 1);
                if (q_a.size() == 0) chk("extra_ray_a", q_a.size(), 1);
                else begin
                    cmp_ray("ray_a", q_a[0], px_a, py_a, dx_a, dy_a, dz_a, ox_a, oy_a, oz_a, sof_a, eol_a);
                    if (ray_ready_a) begin
                        e = q_a.pop_front();
                        hs_cnt_a++;
                        if (e.last) pend_a = 1;
                    end
                end
            end else begin
                chk("busy_idle_a", busy_a, 0);
                chk("sof_idle_a", sof_a, 0);
                chk("eol_idle_a", eol_a, 0);
            end
        end
    end

    initial begin
        ray_t e;
        forever begin
            @(negedge clk);
            chk("done_b", done_b, int'(pend_b));
            if (done_b) done_cnt_b++;
            pend_b = 0;
            if (ray_valid_b) begin
                if (q_b.size() == 0) chk("extra_ray_b", q_b.size(), 1);
                else begin
                    cmp_ray("ray_b", q_b[0], px_b, py_b, dx_b, dy_b, dz_b, ox_b, oy_b, oz_b, sof_b, eol_b);
                    if (ray_ready_b) begin
                        e = q_b.pop_front();
                        hs_cnt_b++;
                        if (e.last) pend_b = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame_a(input int cx, input int cy, input int cz);
        ray_q_t f;
        f = gen_frame(HA, VA, int'(SA), int'(FA), cx, cy, cz);
        foreach (f[i]) q_a.push_back(f[i]);
        cam_x_a = 12'(cx); cam_y_a = 12'(cy); cam_z_a = 12'(cz);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cam_x_a = 12'sh7ff; cam_y_a = -12'sd2048; cam_z_a = 12'sd99;
        chk("latency_valid_a", ray_valid_a, 1);
    endtask

    task automatic start_frame_b(input int cx, input int cy, input int cz);
        ray_q_t f;
        f = gen_frame(HB, VB, int'(SB), int'(FB), cx, cy, cz);
        foreach (f[i]) q_b.push_back(f[i]);
        cam_x_b = 12'(cx); cam_y_b = 12'(cy); cam_z_b = 12'(cz);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("latency_valid_b", ray_valid_b, 1);
    endtask

    task automatic wait_done_a(input int budget);
        int prev;
        prev = done_cnt_a;
        for (int c = 0; c < budget && done_cnt_a == prev; c++) tick();
        chk("frame_done_a", done_cnt_a, prev + 1);
        chk("queue_empty_a", q_a.size(), 0);
    endtask

    task automatic wait_hs_a(input int target);
        for (int c = 0; c < 100 && hs_cnt_a < target; c++) tick();
        chk("hs_reach_a", hs_cnt_a, target);
    endtask

    initial begin
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int prev, base;
        rst_a = 1; rst_b = 1; start_a = 1; start_b = 1;
        ray_ready_a = 0; ray_ready_b = 0;
        cam_x_a = 12'sd5; cam_y_a = 12'sd6; cam_z_a = 12'sd7;
        cam_x_b = 12'sd0; cam_y_b = 12'sd0; cam_z_b = 12'sd0;

        // Reset held with start high
        repeat (3) tick();
        chk("rst_valid", ray_valid_a, 0); chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
        chk("rst_ox", ox_a, 0); chk("rst_oy", oy_a, 0); chk("rst_oz", oz_a, 0);
        chk("rst_dx", dx_a, 0); chk("rst_dy", dy_a, 0); chk("rst_dz", dz_a, 0);
        chk("rst_px", px_a, 0); chk("rst_py", py_a, 0);
        rst_a = 0; rst_b = 0; start_a = 0; start_b = 0;
        tick();
        chk("idle_after_rst", ray_valid_a, 0);

        // Full frame, ready held high
        ray_ready_a = 1;
        start_frame_a(16, -32, 0);
        chk("first_dx", dx_a, -32); chk("first_dy", dy_a, 16); chk("first_dz", dz_a, 64);
        chk("first_oy", oy_a, -32); chk("first_sof", sof_a, 1);
        tick(); tick(); tick();
        chk("ray4_eol", eol_a, 1);
        wait_done_a(100);
        tick();

        // Back-pressure pattern 1,0,0,1
        prev = done_cnt_a;
        start_frame_a(-100, 50, 7);
        for (int c = 0; c < 200 && done_cnt_a == prev; c++) begin
            ray_ready_a = pat[c % 4];
            tick();
        end
        chk("bp_frame_done_a", done_cnt_a, prev + 1);
        chk("bp_queue_empty_a", q_a.size(), 0);
        tick();

        // start pulsed mid-frame must be ignored
        ray_ready_a = 1;
        prev = done_cnt_a;
        base = hs_cnt_a;
        start_frame_a(5, 6, 7);
        wait_hs_a(base + 4);
        cam_x_a = 12'sd1; cam_y_a = 12'sd2; cam_z_a = 12'sd3;
        start_a = 1;
        tick();
        start_a = 0;
        wait_done_a(100);
        repeat (5) tick();
        chk("ignored_start_valid", ray_valid_a, 0);
        chk("ignored_start_one_done", done_cnt_a, prev + 1);
        chk("ignored_start_rays", hs_cnt_a, base + 12);

        // Reset in the middle of a frame
        prev = done_cnt_a;
        base = hs_cnt_a;
        start_frame_a(32, 32, 32);
        wait_hs_a(base + 5);
        rst_a = 1;
        ray_ready_a = 0;
        tick();
        q_a.delete();
        rst_a = 0;
        chk("midrst_valid", ray_valid_a, 0); chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0); chk("midrst_px", px_a, 0); chk("midrst_ox", ox_a, 0);
        repeat (5) tick();
        chk("midrst_no_done", done_cnt_a, prev);
        ray_ready_a = 1;
        start_frame_a(-16, 48, -8);
        chk("restart_sof", sof_a, 1);
        wait_done_a(100);

        // Saturating direction on the wide-step instance
        ray_ready_b = 1;
        prev = done_cnt_b;
        start_frame_b(0, 0, 0);
        chk("sat_px0_dx", dx_b, -2048);
        for (int c = 0; c < 50 && hs_cnt_b < 7; c++) tick();
        chk("sat_px7_px", px_b, 7);
        chk("sat_px7_dx", dx_b, 2047);
        for (int c = 0; c < 100 && done_cnt_b == prev; c++) tick();
        chk("frame_done_b", done_cnt_b, prev + 1);
        chk("queue_empty_b", q_b.size(), 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
